// File: rtl/memory_access_pkg.sv
// Shared types and constants for the memory stage.
package memory_access_pkg;

    localparam int unsigned N_DEFAULT = 64;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/memory_access_flopenr.sv
// Parameterised-width register with synchronous active-high reset and load enable.
module flopenr #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/memory_access.sv
// Memory stage: EX/MEM register, branch resolution and req/ack data-memory access
// with back-pressure towards execute while an access is outstanding.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         valid_E,
    output logic         ready_M,
    input  logic         Branch_E,
    input  logic         MemRead_E,
    input  logic         MemWrite_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic         zero_E,

    output logic         dmem_req,
    output logic         dmem_we,
    output logic [N-1:0] dmem_addr,
    output logic [N-1:0] dmem_wdata,
    input  logic [N-1:0] dmem_rdata,
    input  logic         dmem_ack,

    output logic         valid_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] readData_M
);

    localparam int unsigned REG_W = 3 * N + 4;

    mem_state_t     state_q;
    mem_state_t     state_d;
    logic           accept;
    logic           valid_d;
    logic           pcsrc_d;
    logic           load_done;

    logic [REG_W-1:0] exmem_d;
    logic [REG_W-1:0] exmem_q;

    logic           branch_q;
    logic           memread_q;
    logic           memwrite_q;
    logic           zero_q;
    logic [N-1:0]   pcbranch_q;
    logic [N-1:0]   aluresult_q;
    logic [N-1:0]   writedata_q;

    assign ready_M = (state_q == IDLE);
    assign accept  = valid_E & ready_M;

    // EX/MEM pipeline register, loaded on every accepted instruction
    assign exmem_d = {Branch_E, MemRead_E, MemWrite_E, zero_E,
                      PCBranch_E, aluResult_E, writeData_E};

    flopenr #(
        .W (REG_W)
    ) u_exmem (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .d     (exmem_d),
        .q     (exmem_q)
    );

    assign {branch_q, memread_q, memwrite_q, zero_q,
            pcbranch_q, aluresult_q, writedata_q} = exmem_q;

    // Request fields come straight from the EX/MEM register, so they stay stable until ack
    assign dmem_req    = (state_q == ACCESS);
    assign dmem_we     = memwrite_q;
    assign dmem_addr   = aluresult_q;
    assign dmem_wdata  = writedata_q;
    assign aluResult_M = aluresult_q;
    assign PCBranch_M  = pcbranch_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            valid_M    <= 1'b0;
            PCSrc_M    <= 1'b0;
            readData_M <= '0;
        end else begin
            state_q <= state_d;
            valid_M <= valid_d;
            PCSrc_M <= pcsrc_d;
            if (load_done) begin
                readData_M <= dmem_rdata;
            end
        end
    end

    // Next state and completion decode; a read+write op completes as a store
    always_comb begin
        state_d   = state_q;
        valid_d   = 1'b0;
        pcsrc_d   = 1'b0;
        load_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (MemRead_E || MemWrite_E) begin
                        state_d = ACCESS;
                    end else begin
                        valid_d = 1'b1;
                        pcsrc_d = Branch_E & zero_E;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_d   = IDLE;
                    valid_d   = 1'b1;
                    pcsrc_d   = branch_q & zero_q;
                    load_done = memread_q & ~memwrite_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed plus randomized checks of memory_access against a transaction-level model.
module tb_memory_access;

    localparam int unsigned N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_E;
    logic         ready_M;
    logic         Branch_E, MemRead_E, MemWrite_E, zero_E;
    logic [N-1:0] PCBranch_E, aluResult_E, writeData_E;
    logic         dmem_req, dmem_we, dmem_ack;
    logic [N-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic         valid_M, PCSrc_M;
    logic [N-1:0] PCBranch_M, aluResult_M, readData_M;

    int total = 0;
    int bad   = 0;

    // Model: architectural results of the most recent instructions
    logic [N-1:0] exp_alu = '0;
    logic [N-1:0] exp_pcb = '0;
    logic [N-1:0] exp_rd  = '0;

    memory_access #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_E     (valid_E),
        .ready_M     (ready_M),
        .Branch_E    (Branch_E),
        .MemRead_E   (MemRead_E),
        .MemWrite_E  (MemWrite_E),
        .PCBranch_E  (PCBranch_E),
        .aluResult_E (aluResult_E),
        .writeData_E (writeData_E),
        .zero_E      (zero_E),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .valid_M     (valid_M),
        .PCSrc_M     (PCSrc_M),
        .PCBranch_M  (PCBranch_M),
        .aluResult_M (aluResult_M),
        .readData_M  (readData_M)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction through the stage; k = wait cycles before ack for memory ops
    task automatic do_insn(input logic br, input logic mr, input logic mw, input logic z,
                           input logic [N-1:0] pcb, input logic [N-1:0] alu,
                           input logic [N-1:0] wd, input int k, input logic [N-1:0] rdata);
        check("ready_before_accept", N'(ready_M), N'(1));
        valid_E     = 1'b1;
        Branch_E    = br;
        MemRead_E   = mr;
        MemWrite_E  = mw;
        zero_E      = z;
        PCBranch_E  = pcb;
        aluResult_E = alu;
        writeData_E = wd;
        step();
        valid_E     = 1'b0;
        aluResult_E = N'($urandom);
        exp_alu = alu;
        exp_pcb = pcb;
        if (mr || mw) begin
            for (int i = 0; i <= k; i++) begin
                check("req_high",   N'(dmem_req), N'(1));
                check("req_addr",   dmem_addr, alu);
                check("req_wdata",  dmem_wdata, wd);
                check("req_we",     N'(dmem_we), N'(mw));
                check("ready_busy", N'(ready_M), N'(0));
                check("valid_wait", N'(valid_M), N'(0));
                dmem_ack   = (i == k);
                dmem_rdata = (i == k) ? rdata : N'({$urandom, $urandom});
                step();
            end
            dmem_ack = 1'b0;
            if (mr && !mw) exp_rd = rdata;
            check("req_dropped", N'(dmem_req), N'(0));
        end else begin
            check("req_idle_alu", N'(dmem_req), N'(0));
        end
        check("valid_done",  N'(valid_M), N'(1));
        check("pcsrc",       N'(PCSrc_M), N'(br & z));
        check("alu_result",  aluResult_M, exp_alu);
        check("pc_branch",   PCBranch_M, exp_pcb);
        check("read_data",   readData_M, exp_rd);
        check("ready_after", N'(ready_M), N'(1));
    endtask

    task automatic idle_cycle(input logic stray_ack);
        dmem_ack   = stray_ack;
        dmem_rdata = N'({$urandom, $urandom});
        step();
        dmem_ack = 1'b0;
        check("idle_valid",  N'(valid_M), N'(0));
        check("idle_pcsrc",  N'(PCSrc_M), N'(0));
        check("idle_rdata",  readData_M, exp_rd);
        check("idle_alu",    aluResult_M, exp_alu);
        check("idle_req",    N'(dmem_req), N'(0));
    endtask

    initial begin
        logic br, mr, mw, z;
        // Reset with a simultaneous valid instruction: reset must win
        reset = 1'b1; valid_E = 1'b1;
        Branch_E = 1'b1; MemRead_E = 1'b0; MemWrite_E = 1'b0; zero_E = 1'b1;
        PCBranch_E = 64'h1234; aluResult_E = 64'h99; writeData_E = 64'h77;
        dmem_ack = 1'b0; dmem_rdata = '0;
        step();
        step();
        check("rst_valid", N'(valid_M), N'(0));
        check("rst_pcsrc", N'(PCSrc_M), N'(0));
        check("rst_alu",   aluResult_M, '0);
        check("rst_pcb",   PCBranch_M, '0);
        check("rst_rdata", readData_M, '0);
        check("rst_req",   N'(dmem_req), N'(0));
        check("rst_addr",  dmem_addr, '0);
        check("rst_ready", N'(ready_M), N'(1));
        reset = 1'b0; valid_E = 1'b0;
        idle_cycle(1'b1);

        // Directed: ALU op, 3-wait load, immediate store, branches
        do_insn(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h10, 64'h0, 0, '0);
        idle_cycle(1'b0);
        do_insn(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h40, 64'h0, 3, 64'hDEADBEEF);
        idle_cycle(1'b0);
        do_insn(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h8, 64'h55, 0, 64'hBAD);
        idle_cycle(1'b0);
        do_insn(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h18, 64'h66, 1, 64'hBAD2);
        do_insn(1'b1, 1'b0, 1'b0, 1'b1, 64'h100, 64'h0, 64'h0, 0, '0);
        do_insn(1'b1, 1'b0, 1'b0, 1'b0, 64'h200, 64'h1, 64'h0, 0, '0);
        idle_cycle(1'b1);

        // Throughput: four back-to-back ALU ops
        for (int i = 0; i < 4; i++) begin
            do_insn(1'b0, 1'b0, 1'b0, 1'b0, N'(i), N'(64'h1000 + i), '0, 0, '0);
        end
        idle_cycle(1'b0);

        // Reset mid-access, then a stray ack
        valid_E = 1'b1; Branch_E = 1'b0; MemRead_E = 1'b1; MemWrite_E = 1'b0;
        aluResult_E = 64'h80; PCBranch_E = 64'h44;
        step();
        valid_E = 1'b0;
        check("midrst_req_before", N'(dmem_req), N'(1));
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_alu = '0; exp_pcb = '0; exp_rd = '0;
        check("midrst_req",   N'(dmem_req), N'(0));
        check("midrst_addr",  dmem_addr, '0);
        check("midrst_alu",   aluResult_M, '0);
        check("midrst_pcb",   PCBranch_M, '0);
        check("midrst_rdata", readData_M, '0);
        check("midrst_ready", N'(ready_M), N'(1));
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // Randomized instruction mix
        for (int n = 0; n < 60; n++) begin
            br = 1'($urandom); z = 1'($urandom);
            mr = ($urandom_range(0, 2) == 0);
            mw = ($urandom_range(0, 2) == 0);
            do_insn(br, mr, mw, z, N'({$urandom, $urandom}), N'({$urandom, $urandom}),
                    N'({$urandom, $urandom}), int'($urandom_range(0, 3)),
                    N'({$urandom, $urandom}));
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_access.md
# memory_access

Memory stage sitting directly downstream of the execute stage. Latches execute-stage results (ALU result, store data, branch target, zero flag) into an EX/MEM register. Resolves the branch decision and performs load/store accesses to a variable-latency data memory through a req/ack handshake. While an access is outstanding it back-pressures execute.

## Interface
Parameters:
- N, 64, datapath/address width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_E  in  1  execute stage presents a valid instruction this cycle.
- ready_M  out  1  stage can accept; transfer occurs when valid_E & ready_M.
- Branch_E, MemRead_E, MemWrite_E  in  1 each  control bits travelling with the instruction.
- PCBranch_E, aluResult_E, writeData_E  in  N each  execute-stage results.
- zero_E  in  1  ALU zero flag.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr, dmem_wdata  out  N each  request address and store data.
- dmem_rdata  in  N  load data, valid when dmem_ack = 1.
- dmem_ack  in  1  memory completes request this cycle.
- valid_M  out  1  one-cycle pulse: instruction finished memory stage.
- PCSrc_M  out  1  take branch; only ever high together with valid_M.
- PCBranch_M, aluResult_M, readData_M  out  N each  results for writeback/fetch.

## Operation
- States: IDLE, ACCESS.
- ready_M = (state == IDLE), combinational from the state register.
- IDLE with accept and no memory op:
  - Capture all _E fields into the EX/MEM register.
  - Next cycle: valid_M = 1 and PCSrc_M = Branch & zero.
  - Remain IDLE.
- IDLE with accept and MemRead or MemWrite:
  - Capture fields and go to ACCESS.
  - valid_M = 0 next cycle.
- ACCESS:
  - dmem_req = 1.
  - dmem_addr = registered aluResult; dmem_wdata = registered writeData; dmem_we = registered MemWrite.
  - All four are held stable until ack.
  - On dmem_ack: for a load, capture dmem_rdata into readData_M; assert valid_M next cycle; go IDLE.
- MemRead & MemWrite both set: treated as a store. readData_M is unchanged.
- readData_M changes only on load completion and holds otherwise.
- aluResult_M and PCBranch_M hold their last captured value.
- dmem_ack while IDLE is ignored.
- No accept in IDLE: valid_M = 0 next cycle; registers hold.
- Address is passed through unchanged (doubleword access). Alignment is not checked.

## Timing
- Reset (synchronous): state = IDLE; all registered outputs = 0 (valid_M, PCSrc_M, PCBranch_M, aluResult_M, readData_M).
- Reset also forces dmem_req/dmem_we/dmem_addr/dmem_wdata = 0 from the following cycle.
- Reset has priority over accept and ack in the same cycle.
- Reset mid-ACCESS abandons the access; a later stray ack is ignored.
- Non-memory latency: accept at edge t gives valid_M high in cycle t..t+1.
- Memory latency: accept at edge t puts dmem_req high from cycle t+1. Ack in cycle t+1+k gives valid_M in the cycle after, so total is 2+k cycles.
- Minimum memory latency: ack in the first req cycle, i.e. k = 0.
- Back-to-back non-memory instructions run at one per cycle.
- The next instruction is accepted in the cycle after ack, since ready_M returns high once the state is back in IDLE.
- No backpressure from downstream: valid_M is consumed unconditionally.

## Structure
- Shared package:
  - mem_state_t enum {IDLE, ACCESS}.
  - Default width constant N = 64.
- Sub-module flopenr (parameterised-width, synchronous-reset, enabled register) implements the EX/MEM pipeline register.
- FSM and handshake logic live in the top module.

## Test plan
- ALU op: accept aluResult_E=0x10, no mem op -> valid_M=1 next cycle, aluResult_M=0x10, dmem_req stays 0.
- Load with 3-cycle wait:
  - Stimulus: accept MemRead, aluResult_E=0x40; ack asserted 3 cycles after req rises, dmem_rdata=0xDEADBEEF.
  - Response: dmem_addr=0x40 and dmem_we=0 held throughout; ready_M=0 for 4 cycles; readData_M=0xDEADBEEF and valid_M pulse one cycle after ack.
- Store with immediate ack: accept MemWrite, aluResult_E=0x8, writeData_E=0x55 -> req with we=1, addr=0x8, wdata=0x55 for exactly one cycle; valid_M the next cycle; readData_M unchanged.
- Branch:
  - Branch_E=1, zero_E=1, PCBranch_E=0x100 -> PCSrc_M=1 with valid_M, PCBranch_M=0x100.
  - Repeat with zero_E=0 -> PCSrc_M=0.
- Reset mid-ACCESS: reset during the req wait -> req low the following cycle, all outputs 0; an ack arriving after reset produces no valid_M.
- Throughput: 4 back-to-back ALU ops -> 4 consecutive valid_M cycles, ready_M constantly 1.
